// File: rtl/ts_channel_rr_mux_if.sv
// ts_channel_rr_mux_if
//   Bundles the channel-side inputs and the forwarded outputs of the
//   round-robin channel multiplexer.
//   master : the channel sources / consumer (drives data_in, data_in_valid)
//   slave  : the multiplexer itself
//   Signals:
//     data_in        [NCH*DW]  packed channel words, channel k at [k*DW +: DW]
//     data_in_valid  [NCH]     per-channel valid, held for a whole packet
//     rd_ack         [NCH]     one-hot grant pulse
//     data_out       [DW]      forwarded word (registered)
//     data_out_valid           forwarded valid (registered)
//     grant_ch       [CW]      channel currently or last granted
//     busy                     multiplexer not idle
//     overrun                  pulse when a grant is cut at the word limit
interface ts_channel_rr_mux_if #(
  parameter int NCH = 4,
  parameter int DW  = 33,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH*DW-1:0] data_in;
  logic [NCH-1:0]    data_in_valid;
  logic [NCH-1:0]    rd_ack;
  logic [DW-1:0]     data_out;
  logic              data_out_valid;
  logic [CW-1:0]     grant_ch;
  logic              busy;
  logic              overrun;

  modport master (
    output data_in, data_in_valid,
    input  rd_ack, data_out, data_out_valid, grant_ch, busy, overrun
  );

  modport slave (
    input  data_in, data_in_valid,
    output rd_ack, data_out, data_out_valid, grant_ch, busy, overrun
  );
endinterface

// File: rtl/ts_channel_rr_mux.sv
// ts_channel_rr_mux
//   Round-robin multiplexer of NCH packet channels onto one output stream.
//   A channel is granted with a one-cycle rd_ack pulse, its words are
//   forwarded one cycle late while it stays valid (at most MAX_WORDS per
//   grant), then an END cycle and GAP idle cycles separate packets.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    ts_channel_rr_mux_if.slave (channel inputs, forwarded outputs)
module ts_channel_rr_mux #(
  parameter int NCH       = 4,
  parameter int DW        = 33,
  parameter int GAP       = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic               clk,
  input  logic               reset,
  ts_channel_rr_mux_if.slave bus
);
  localparam int             CW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0]  LAST_CH  = CW'(NCH - 1);
  localparam logic [CW:0]    NCH_W    = (CW + 1)'(NCH);
  localparam logic [15:0]    MAX_W    = 16'(MAX_WORDS);
  localparam logic [5:0]     GAP_LAST = 6'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_XFER,
    S_END,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     grant_ch_q, grant_ch_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [5:0]        gap_cnt_q, gap_cnt_d;
  logic [DW-1:0]     data_out_q, data_out_d;
  logic              data_out_valid_q, data_out_valid_d;
  logic              overrun_q, overrun_d;

  // Selected channel's word and valid.
  logic [DW-1:0]     ch_word [NCH];
  logic [DW-1:0]     sel_word;
  logic              sel_valid;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_word
    assign ch_word[gi] = bus.data_in[gi*DW +: DW];
  end

  assign sel_word  = ch_word[grant_ch_q];
  assign sel_valid = bus.data_in_valid[grant_ch_q];

  // Round-robin pick: rotate the request vector so the channel after the
  // last grant sits at bit 0, isolate the lowest set bit, encode it and
  // rotate the offset back.
  logic [CW-1:0]           rr_ptr;
  logic [NCH-1:0]          req_rot;
  logic [NCH-1:0]          req_low;
  logic [CW-1:0][NCH-1:0]  enc_bits;
  logic [CW-1:0]           rr_off;
  logic [CW:0]             rr_sum;
  logic [CW-1:0]           rr_pick;
  logic                    rr_found;

  assign rr_ptr   = (grant_ch_q == LAST_CH) ? '0 : grant_ch_q + CW'(1);
  assign req_rot  = NCH'({bus.data_in_valid, bus.data_in_valid} >> rr_ptr);
  assign req_low  = req_rot & (~req_rot + NCH'(1));
  assign rr_found = |bus.data_in_valid;

  for (genvar gb = 0; gb < CW; gb++) begin : g_enc
    for (genvar gi = 0; gi < NCH; gi++) begin : g_bit
      if (((gi >> gb) & 1) == 1) begin : g_one
        assign enc_bits[gb][gi] = req_low[gi];
      end else begin : g_zero
        assign enc_bits[gb][gi] = 1'b0;
      end
    end
    assign rr_off[gb] = |enc_bits[gb];
  end

  assign rr_sum  = {1'b0, rr_ptr} + {1'b0, rr_off};
  assign rr_pick = (rr_sum >= NCH_W) ? CW'(rr_sum - NCH_W) : rr_sum[CW-1:0];

  // Next-state and output logic.
  always_comb begin
    state_d          = state_q;
    grant_ch_d       = grant_ch_q;
    word_cnt_d       = word_cnt_q;
    gap_cnt_d        = gap_cnt_q;
    data_out_d       = '0;
    data_out_valid_d = 1'b0;
    overrun_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          grant_ch_d = rr_pick;
          word_cnt_d = '0;
          state_d    = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_XFER;
      end
      S_XFER: begin
        if (!sel_valid) begin
          state_d = S_END;
        end else if (word_cnt_q == MAX_W) begin
          // Limit already forwarded: the word offered now is dropped.
          state_d   = S_END;
          overrun_d = 1'b1;
        end else begin
          data_out_d       = sel_word;
          data_out_valid_d = 1'b1;
          word_cnt_d       = word_cnt_q + 16'd1;
        end
      end
      S_END: begin
        gap_cnt_d = '0;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      grant_ch_q       <= LAST_CH;
      word_cnt_q       <= '0;
      gap_cnt_q        <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      overrun_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      grant_ch_q       <= grant_ch_d;
      word_cnt_q       <= word_cnt_d;
      gap_cnt_q        <= gap_cnt_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      overrun_q        <= overrun_d;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ack
    assign bus.rd_ack[gi] = (state_q == S_ACK) && (grant_ch_q == CW'(gi));
  end

  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = data_out_valid_q;
  assign bus.grant_ch       = grant_ch_q;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_ts_channel_rr_mux.sv
// tb_ts_channel_rr_mux
//   Directed scenarios plus randomized traffic for ts_channel_rr_mux, checked
//   every cycle against a transaction-level reference model. MAX_WORDS is 6
//   so a 5-word packet passes untruncated while continuous sources get cut.
module tb_ts_channel_rr_mux;
  localparam int NCH  = 4;
  localparam int DW   = 33;
  localparam int GAP  = 10;
  localparam int MAXW = 6;
  localparam int CW   = 2;
  localparam logic [DW-1:0] WBASE = 33'h1_0000_0000;

  localparam int M_IDLE = 0;
  localparam int M_ACK  = 1;
  localparam int M_XFER = 2;
  localparam int M_COOL = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ts_channel_rr_mux_if #(.NCH(NCH), .DW(DW)) bus ();

  ts_channel_rr_mux #(
    .NCH(NCH), .DW(DW), .GAP(GAP), .MAX_WORDS(MAXW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_mode  = M_IDLE;
  logic [CW-1:0] m_grant = CW'(NCH - 1);
  int            m_words = 0;
  int            m_cool  = 0;
  logic [DW-1:0] m_dout  = '0;
  logic          m_dval  = 1'b0;
  logic          m_ovr   = 1'b0;
  logic          m_ok    = 1'b0;
  int            rr_next;

  // First valid channel after 'last', wrapping modulo NCH; -1 if none.
  function automatic int rr_pick(input int last, input logic [NCH-1:0] v);
    for (int i = 1; i <= NCH; i++) begin
      int c;
      c = (last + i) % NCH;
      if (((v >> c) & NCH'(1)) != '0) return c;
    end
    return -1;
  endfunction

  assign rr_next = rr_pick(int'(m_grant), bus.data_in_valid);

  always @(posedge clk) begin
    m_dout <= '0;
    m_dval <= 1'b0;
    m_ovr  <= 1'b0;
    if (reset) begin
      m_mode  <= M_IDLE;
      m_grant <= CW'(NCH - 1);
      m_words <= 0;
      m_cool  <= 0;
      m_ok    <= 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (rr_next >= 0) begin
            m_mode  <= M_ACK;
            m_grant <= CW'(rr_next);
          end
        end
        M_ACK: begin
          m_mode  <= M_XFER;
          m_words <= 0;
        end
        M_XFER: begin
          if (!bus.data_in_valid[m_grant]) begin
            m_mode <= M_COOL;
            m_cool <= GAP + 1;
          end else if (m_words == MAXW) begin
            m_mode <= M_COOL;
            m_cool <= GAP + 1;
            m_ovr  <= 1'b1;
          end else begin
            m_dout  <= bus.data_in[int'(m_grant)*DW +: DW];
            m_dval  <= 1'b1;
            m_words <= m_words + 1;
          end
        end
        default: begin
          m_cool <= m_cool - 1;
          if (m_cool == 1) m_mode <= M_IDLE;
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      check("busy", 64'(bus.busy), 64'(m_mode != M_IDLE));
      check("rd_ack", 64'(bus.rd_ack), (m_mode == M_ACK) ? 64'(NCH'(1) << m_grant) : 64'd0);
      check("grant_ch", 64'(bus.grant_ch), 64'(m_grant));
      check("data_out_valid", 64'(bus.data_out_valid), 64'(m_dval));
      check("data_out", 64'(bus.data_out), 64'(m_dout));
      check("overrun", 64'(bus.overrun), 64'(m_ovr));
    end
  end

  // ---------------- grant log ----------------
  int g_ch[$];
  int g_cyc[$];
  int g_words[$];
  int g_ovr[$];

  function automatic int onehot_idx(input logic [NCH-1:0] v);
    for (int k = 0; k < NCH; k++) begin
      if (((v >> k) & NCH'(1)) != '0) return k;
    end
    return -1;
  endfunction

  initial forever begin
    @(negedge clk);
    if (bus.rd_ack != '0) begin
      g_ch.push_back(onehot_idx(bus.rd_ack));
      g_cyc.push_back(cyc);
      g_words.push_back(0);
      g_ovr.push_back(0);
      $display("grant ch%0d at cycle %0d", onehot_idx(bus.rd_ack), cyc);
    end
    if (g_words.size() > 0) begin
      if (bus.data_out_valid === 1'b1) g_words[g_words.size()-1]++;
      if (bus.overrun === 1'b1) g_ovr[g_ovr.size()-1]++;
    end
  end

  task automatic clear_log();
    g_ch.delete();
    g_cyc.delete();
    g_words.delete();
    g_ovr.delete();
  endtask

  function automatic int log_ch(input int i);
    return (i < g_ch.size()) ? g_ch[i] : -1;
  endfunction
  function automatic int log_words(input int i);
    return (i < g_words.size()) ? g_words[i] : -1;
  endfunction
  function automatic int log_ovr(input int i);
    return (i < g_ovr.size()) ? g_ovr[i] : -1;
  endfunction
  function automatic int log_gap(input int i);
    return (i < g_cyc.size() && i > 0) ? g_cyc[i] - g_cyc[i-1] : -1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic v, input logic [DW-1:0] w);
    bus.data_in[k*DW +: DW] = w;
    bus.data_in_valid = (bus.data_in_valid & ~(NCH'(1) << k)) | (NCH'(v) << k);
  endtask

  task automatic drop_all();
    bus.data_in       = '0;
    bus.data_in_valid = '0;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic do_reset();
    next_cycle();
    reset = 1'b1;
    drop_all();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic settle(input int n);
    drop_all();
    repeat (n) next_cycle();
  endtask

  int hold[NCH];
  int exp_order[3] = '{0, 1, 3};

  initial begin
    drop_all();
    reset = 1'b1;
    repeat (3) next_cycle();
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_grant_ch", 64'(bus.grant_ch), 64'd3);
    check("rst_rd_ack", 64'(bus.rd_ack), 64'd0);
    check("rst_dvalid", 64'(bus.data_out_valid), 64'd0);
    check("rst_overrun", 64'(bus.overrun), 64'd0);
    repeat (2) next_cycle();

    // Single 5-word packet on ch2.
    clear_log();
    for (int i = 0; i <= GAP + 10; i++) begin
      next_cycle();
      if (i <= 6) set_ch(2, 1'b1, WBASE + DW'((i < 2) ? 1 : i - 1));
      else set_ch(2, 1'b0, '0);
      @(negedge clk);
      if (i == 1) begin
        check("t1_rd_ack", 64'(bus.rd_ack), 64'h4);
        check("t1_model_grant", 64'(m_grant), 64'd2);
      end
      if (i >= 3 && i <= 7) begin
        check("t1_dvalid", 64'(bus.data_out_valid), 64'd1);
        check("t1_word", 64'(bus.data_out), 64'h1_0000_0000 + 64'(i - 2));
      end
      if (i == 8) check("t1_dvalid_end", 64'(bus.data_out_valid), 64'd0);
      if (i == GAP + 8) check("t1_busy_hi", 64'(bus.busy), 64'd1);
      if (i == GAP + 9) check("t1_busy_lo", 64'(bus.busy), 64'd0);
    end
    check("t1_words", 64'(log_words(0)), 64'd5);
    check("t1_overrun", 64'(log_ovr(0)), 64'd0);

    // All channels rise together after reset.
    do_reset();
    clear_log();
    for (int i = 0; i < 45; i++) begin
      next_cycle();
      for (int k = 0; k < NCH; k++) set_ch(k, 1'b1, rand_word());
    end
    settle(GAP + 6);
    check("t2_first", 64'(log_ch(0)), 64'd0);
    check("t2_second", 64'(log_ch(1)), 64'd1);

    // Fairness with truncation: ch0, ch1, ch3 continuously valid.
    do_reset();
    clear_log();
    for (int i = 0; i < 110; i++) begin
      next_cycle();
      set_ch(0, 1'b1, rand_word());
      set_ch(1, 1'b1, rand_word());
      set_ch(3, 1'b1, rand_word());
    end
    settle(GAP + 6);
    check("t3_grants", 64'(g_ch.size()), 64'd6);
    for (int j = 0; j < 6; j++) begin
      check("t3_order", 64'(log_ch(j)), 64'(exp_order[j % 3]));
      check("t3_words", 64'(log_words(j)), 64'(MAXW));
      check("t3_overrun", 64'(log_ovr(j)), 64'd1);
      if (j > 0) check("t3_spacing", 64'(log_gap(j)), 64'(MAXW + GAP + 4));
    end

    // ch1 valid for one cycle only: drops during ACK.
    clear_log();
    for (int i = 0; i <= GAP + 5; i++) begin
      next_cycle();
      if (i == 0) set_ch(1, 1'b1, rand_word());
      else set_ch(1, 1'b0, '0);
      @(negedge clk);
      if (i == 1) check("t4_rd_ack", 64'(bus.rd_ack), 64'h2);
      if (i == GAP + 3) check("t4_busy_hi", 64'(bus.busy), 64'd1);
      if (i == GAP + 4) check("t4_busy_lo", 64'(bus.busy), 64'd0);
    end
    check("t4_grants", 64'(g_ch.size()), 64'd1);
    check("t4_words", 64'(log_words(0)), 64'd0);
    check("t4_overrun", 64'(log_ovr(0)), 64'd0);

    // Reset on the 3rd forwarded word of ch2, then ch1+ch3 request.
    clear_log();
    for (int i = 0; i <= 9; i++) begin
      next_cycle();
      if (i <= 4) set_ch(2, 1'b1, WBASE + DW'((i < 2) ? 1 : i - 1));
      if (i == 4) reset = 1'b1;
      if (i == 5) begin
        reset = 1'b0;
        drop_all();
        clear_log();
      end
      if (i == 6) begin
        set_ch(1, 1'b1, rand_word());
        set_ch(3, 1'b1, rand_word());
      end
      @(negedge clk);
      if (i == 4) check("t5_word2", 64'(bus.data_out), 64'h1_0000_0002);
      if (i == 5) begin
        check("t5_dvalid", 64'(bus.data_out_valid), 64'd0);
        check("t5_busy", 64'(bus.busy), 64'd0);
        check("t5_grant_ch", 64'(bus.grant_ch), 64'd3);
      end
      if (i == 7) check("t5_rd_ack", 64'(bus.rd_ack), 64'h2);
    end
    settle(GAP + 6);
    check("t5_first", 64'(log_ch(0)), 64'd1);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < NCH; k++) hold[k] = 0;
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      reset = ($urandom_range(0, 599) == 0);
      for (int k = 0; k < NCH; k++) begin
        if (hold[k] > 0) begin
          hold[k]--;
          set_ch(k, 1'b1, rand_word());
        end else if ($urandom_range(0, 7) == 0) begin
          hold[k] = int'($urandom_range(1, 14));
          set_ch(k, 1'b1, rand_word());
        end else begin
          set_ch(k, 1'b0, rand_word());
        end
      end
    end
    reset = 1'b0;
    settle(GAP + 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
